bar_graph_plotter: RTL and testbench
====================================

// Module: bar_graph_plotter
// PURPOSE
//  Multi-bar successor to the single-bar datapath. It has an FSM and start/done/busy control.
//  On start it latches NUM_BARS heights and colours and emits one pixel per cycle into the VGA adapter.
//  Each bar slot is a full BAR_W x MAX_H rectangle: the bar colour up to its height and BG_COLOR
//  above it, so a redraw erases the previous bar. It sits between the game/price logic and the VGA adapter.
// PARAMETERS
//  NUM_BARS  4    number of bars drawn per frame
//  BAR_W     32   bar width in pixels
//  MAX_H     200  slot height in pixels; heights are clamped to this value
//  GAP       8    horizontal pixels between adjacent bars
//  X_W       10   x coordinate width (0..639)
//  Y_W       9    y coordinate width (0..479)
//  H_W       8    width of each height field
//  C_W       3    colour width
//  BG_COLOR  0    colour plotted above each bar
// PORTS
//  clk        in   1            system clock; all logic on the rising edge
//  reset      in   1            synchronous, active-high reset
//  start      in   1            request to draw a frame; sampled only in IDLE
//  hold       in   1            back-pressure: freezes the scan and the current pixel
//  origin_x   in   X_W          x of the left column of bar 0
//  origin_y   in   Y_W          y of the baseline row (bottom); must be >= MAX_H-1
//  heights    in   NUM_BARS*H_W packed heights; bar i at [i*H_W +: H_W]
//  colours    in   NUM_BARS*C_W packed colours; bar i at [i*C_W +: C_W]
//  busy       out  1            high from LOAD until DONE inclusive
//  done       out  1            one-cycle pulse after the last pixel
//  plot       out  1            x_coord/y_coord/colour are a valid pixel write
//  x_coord    out  X_W          pixel x
//  y_coord    out  Y_W          pixel y
//  colour     out  C_W          pixel colour
// BEHAVIOUR
//  All outputs are registered. On reset: busy=0, done=0, plot=0, x_coord=0, y_coord=0, colour=0,
//   state=IDLE, all counters=0.
//  FSM states: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//   IDLE: if start=1, latch origin/heights/colours and go to LOAD.
//    start=1 outside IDLE is ignored (no queuing).
//   LOAD: clamp each height to min(h,MAX_H) and clear counters; go to DRAW.
//   DRAW: one pixel per cycle while hold=0.
//   DONE: done=1 and busy=1 for exactly one cycle, plot=0; then go to IDLE.
//  Timing: start sampled at edge 0, LOAD at edge 1, first plot=1 visible after edge 2.
//   With hold=0, exactly NUM_BARS*BAR_W*MAX_H consecutive plot cycles, then done.
//  Scan order: col is innermost (0..BAR_W-1), then row (0..MAX_H-1), then bar (0..NUM_BARS-1).
//  Pixel values:
//   x_coord = origin_x + bar*(BAR_W+GAP) + col
//   y_coord = origin_y - row
//   colour  = (row < height[bar]) ? colours[bar] : BG_COLOR
//   Arithmetic is done at X_W/Y_W width and wraps silently; keeping the graph on screen is the caller's job.
//  Boundary cases:
//   height=0: the whole slot is BG_COLOR.
//   height>=MAX_H: the whole slot is the bar colour.
//   Counter wrap: col wraps to 0 and increments row; row wraps to 0 and increments bar;
//    the last pixel (bar=NUM_BARS-1, row=MAX_H-1, col=BAR_W-1) goes to DONE.
//  hold (DRAW only): plot and the current coordinates stay unchanged and counters freeze.
//   Each pixel is therefore presented until a cycle with hold=0 consumes it.
//   hold is ignored in IDLE, LOAD and DONE.
//  Mid-frame input changes: heights, colours and origin are latched, so changes after start have no effect.
//  reset during any state: return to IDLE with reset values next cycle; no done pulse.
//  start on the cycle after done: accepted, new frame begins (back-to-back frames allowed).
// TESTING
//  Bench params: NUM_BARS=2, BAR_W=4, MAX_H=8, GAP=2, C_W=3, BG_COLOR=0.
//  1. origin=(10,100), heights={3,5}, colours={3'b100,3'b010}
//     -> 64 plot pulses, then done=1 one cycle later.
//     Bar0 x 10..13, bar1 x 16..19; y 100..93.
//     Bar0 rows 0-2 colour 2; bar1 rows 0-4 colour 4; all other pixels 0.
//  2. heights={0,255}
//     -> all bar0 pixels colour 0 and all bar1 pixels its colour (clamped); still 64 pixels.
//  3. hold=1 for 5 cycles at pixel 10
//     -> same x/y/colour held; no skipped or duplicated pixels; done 5 cycles later than in test 1.
//  4. start pulsed during DRAW; heights changed mid-frame
//     -> ignored; output matches test 1; exactly one done pulse.
//  5. reset asserted at pixel 20
//     -> next cycle plot=0, busy=0, done=0; a new start gives a full 64-pixel frame.
//  6. start held high continuously
//     -> frames back-to-back; DONE is followed by IDLE and then LOAD, with a 2-cycle gap between frames.

Source files
------------

// File: rtl/bar_graph_plotter.sv
// Draws NUM_BARS bar slots (bar colour up to height, BG_COLOR above) one pixel per cycle for a VGA adapter.
// First pixel two cycles after start; hold freezes the presented pixel until a cycle with hold=0 consumes it.
module bar_graph_plotter #(
  parameter int NUM_BARS = 4,
  parameter int BAR_W    = 32,
  parameter int MAX_H    = 200,
  parameter int GAP      = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int H_W      = 8,
  parameter int C_W      = 3,
  parameter int BG_COLOR = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hold,
  input  logic [X_W-1:0]          origin_x,
  input  logic [Y_W-1:0]          origin_y,
  input  logic [NUM_BARS*H_W-1:0] heights,
  input  logic [NUM_BARS*C_W-1:0] colours,
  output logic                    busy,
  output logic                    done,
  output logic                    plot,
  output logic [X_W-1:0]          x_coord,
  output logic [Y_W-1:0]          y_coord,
  output logic [C_W-1:0]          colour
);

  localparam int COL_W  = (BAR_W > 1)    ? $clog2(BAR_W)    : 1;
  localparam int ROW_W  = (MAX_H > 1)    ? $clog2(MAX_H)    : 1;
  localparam int BAR_IW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BAR_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(MAX_H - 1);
  localparam logic [BAR_IW-1:0] BAR_LAST = BAR_IW'(NUM_BARS - 1);
  localparam logic [X_W-1:0]    X_STEP   = X_W'(BAR_W + GAP);
  localparam logic [H_W-1:0]    H_MAX    = H_W'(MAX_H);
  localparam logic [C_W-1:0]    BG       = C_W'(BG_COLOR);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [BAR_IW-1:0] bar;
  logic [X_W-1:0]    bar_x;
  logic [X_W-1:0]    org_x;
  logic [Y_W-1:0]    org_y;
  logic [H_W-1:0]    hgt [NUM_BARS];
  logic [C_W-1:0]    clr [NUM_BARS];
  // set once the final pixel of the frame is on the outputs
  logic              last_shown;

  logic              col_end, row_end, at_last, in_bar;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [C_W-1:0]    pix_c;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = DRAW;
      DRAW:    if (!hold && last_shown) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    col_end = (col == COL_LAST);
    row_end = (row == ROW_LAST);
    at_last = col_end && row_end && (bar == BAR_LAST);
    pix_x   = bar_x + X_W'(col);
    pix_y   = org_y - Y_W'(row);
    in_bar  = 32'(row) < 32'(hgt[bar]);
    pix_c   = in_bar ? clr[bar] : BG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      x_coord    <= '0;
      y_coord    <= '0;
      colour     <= '0;
      col        <= '0;
      row        <= '0;
      bar        <= '0;
      bar_x      <= '0;
      org_x      <= '0;
      org_y      <= '0;
      last_shown <= 1'b0;
      for (int i = 0; i < NUM_BARS; i++) begin
        hgt[i] <= '0;
        clr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            org_x <= origin_x;
            org_y <= origin_y;
            for (int i = 0; i < NUM_BARS; i++) begin
              hgt[i] <= heights[i*H_W +: H_W];
              clr[i] <= colours[i*C_W +: C_W];
            end
          end
        end
        LOAD: begin
          col        <= '0;
          row        <= '0;
          bar        <= '0;
          bar_x      <= org_x;
          last_shown <= 1'b0;
          for (int i = 0; i < NUM_BARS; i++)
            hgt[i] <= (hgt[i] > H_MAX) ? H_MAX : hgt[i];
        end
        DRAW: begin
          if (!hold) begin
            if (last_shown) begin
              plot <= 1'b0;
              done <= 1'b1;
            end else begin
              plot       <= 1'b1;
              x_coord    <= pix_x;
              y_coord    <= pix_y;
              colour     <= pix_c;
              last_shown <= at_last;
              if (col_end) begin
                col <= '0;
                if (row_end) begin
                  row   <= '0;
                  bar   <= bar + 1'b1;
                  bar_x <= bar_x + X_STEP;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          plot <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_graph_plotter.sv
// Randomised bench for bar_graph_plotter: stimulus pushes expected pixels and done tokens, a negedge monitor checks them.
module tb_bar_graph_plotter;

  localparam int NB = 2, BW = 4, MH = 8, GP = 2, XW = 10, YW = 9, HW = 8, CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [XW-1:0] origin_x = '0;
  logic [YW-1:0] origin_y = '0;
  logic [15:0]   heights = '0;
  logic [5:0]    colours = '0;
  logic          busy, done, plot;
  logic [XW-1:0] x_coord;
  logic [YW-1:0] y_coord;
  logic [CW-1:0] colour;

  bar_graph_plotter #(
    .NUM_BARS(NB), .BAR_W(BW), .MAX_H(MH), .GAP(GP), .X_W(XW), .Y_W(YW),
    .H_W(HW), .C_W(CW), .BG_COLOR(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .origin_x(origin_x), .origin_y(origin_y), .heights(heights), .colours(colours),
    .busy(busy), .done(done), .plot(plot),
    .x_coord(x_coord), .y_coord(y_coord), .colour(colour)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          tok;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_done = 0;
  int   done_cnt = 0;
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: every slot pixel in scan order, then one done token.
  task automatic push_frame(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                            input logic [15:0] h, input logic [5:0] c);
    exp_t p;
    int   eff;
    for (int b = 0; b < NB; b++) begin
      eff = int'(h[b*HW +: HW]);
      if (eff > MH) eff = MH;
      for (int r = 0; r < MH; r++)
        for (int cc = 0; cc < BW; cc++) begin
          p.tok = 1'b0;
          p.x   = XW'(int'(ox) + b*(BW+GP) + cc);
          p.y   = YW'(int'(oy) - r);
          p.c   = (r < eff) ? c[b*CW +: CW] : 3'd0;
          q.push_back(p);
        end
    end
    p = '0;
    p.tok = 1'b1;
    q.push_back(p);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (plot) begin
        if (q.size() == 0 || q[0].tok) begin
          check("unexpected_plot", {x_coord, y_coord, colour}, 32'hffff_ffff);
        end else begin
          e = q[0];
          check("pixel", {x_coord, y_coord, colour}, {e.x, e.y, e.c});
          if (!hold) void'(q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_plot_low", {busy, plot}, 2'b10);
        if (q.size() == 0 || !q[0].tok) check("done_early", q.size(), 1);
        else void'(q.pop_front());
      end
    end
  end

  // hmode: 0 no hold, 1 five-cycle hold at pixel hold_at, 2 random hold
  task automatic do_frame(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                          input logic [15:0] h, input logic [5:0] c,
                          input int hmode, input int hold_at, input bit midchg,
                          output int lat, output int first_plot);
    origin_x = ox; origin_y = oy; heights = h; colours = c;
    push_frame(ox, oy, h, c);
    exp_done++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    lat = -1;
    first_plot = -1;
    for (int n = 1; n < 3000 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (plot && first_plot < 0) first_plot = n;
      if (done) lat = n;
      case (hmode)
        1:       hold = (n >= hold_at + 2) && (n < hold_at + 7);
        2:       hold = ($urandom_range(3) == 0);
        default: hold = 1'b0;
      endcase
      if (midchg && n == 20) begin
        start = 1'b1; heights = ~h; colours = ~c; origin_x = ox + 10'd5;
      end
      if (midchg && n == 21) start = 1'b0;
    end
    hold = 1'b0;
    if (lat < 0) check("frame_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, fp, d1, d2, p2, idle_cyc;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, plot}, 3'b000);
    check("reset_xyc", {x_coord, y_coord, colour}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ctrl", {busy, done, plot}, 3'b000);

    // basic frame
    do_frame(10'd10, 9'd100, {8'd5, 8'd3}, {3'b100, 3'b010}, 0, 0, 1'b0, lat, fp);
    check("t1_latency", lat, 66);
    check("t1_first_plot", fp, 2);

    // empty and over-height bars
    do_frame(10'd10, 9'd100, {8'd255, 8'd0}, {3'b111, 3'b101}, 0, 0, 1'b0, lat, fp);
    check("t2_latency", lat, 66);

    // five-cycle hold on pixel 10
    do_frame(10'd10, 9'd100, {8'd5, 8'd3}, {3'b100, 3'b010}, 1, 10, 1'b0, lat, fp);
    check("t3_latency", lat, 71);

    // start and input changes mid-frame are ignored
    do_frame(10'd10, 9'd100, {8'd5, 8'd3}, {3'b100, 3'b010}, 0, 0, 1'b1, lat, fp);
    check("t4_latency", lat, 66);

    // reset at pixel 20 aborts the frame without a done pulse
    origin_x = 10'd10; origin_y = 9'd100; heights = {8'd5, 8'd3}; colours = {3'b100, 3'b010};
    push_frame(origin_x, origin_y, heights, colours);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    q.delete();
    check("t5_reset_ctrl", {busy, done, plot}, 3'b000);
    check("t5_reset_xyc", {x_coord, y_coord, colour}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_frame(10'd10, 9'd100, {8'd5, 8'd3}, {3'b100, 3'b010}, 0, 0, 1'b0, lat, fp);
    check("t5_refresh_latency", lat, 66);

    // start held high: two back-to-back frames
    origin_x = 10'd300; origin_y = 9'd20; heights = {8'd8, 8'd1}; colours = {3'b011, 3'b110};
    push_frame(origin_x, origin_y, heights, colours);
    push_frame(origin_x, origin_y, heights, colours);
    exp_done += 2;
    start = 1'b1;
    d1 = -1; d2 = -1; p2 = -1; idle_cyc = 0;
    for (int n = 1; n < 4000 && d2 < 0; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = n;
        else d2 = n;
      end
      if (d1 >= 0 && p2 < 0 && plot) p2 = n;
      if (d1 >= 0 && p2 < 0 && !busy) idle_cyc++;
    end
    start = 1'b0;
    check("t6_second_done", d2 > 0, 1);
    check("t6_done_to_plot", p2 - d1, 4);
    check("t6_idle_cycles", idle_cyc, 1);
    @(posedge clk); #1;

    // random frames, without and with random hold
    for (int k = 0; k < 6; k++) begin
      rx = XW'($urandom_range(639, 0));
      ry = YW'($urandom_range(479, MH - 1));
      do_frame(rx, ry, 16'($urandom), 6'($urandom), (k < 2) ? 0 : 2, 0, 1'b0, lat, fp);
      if (k < 2) check("rand_latency", lat, 66);
    end

    repeat (4) @(posedge clk);
    #1;
    check("done_count", done_cnt, exp_done);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
